// File: rtl/imem_loader_pkg.sv
// rtl/imem_loader_pkg.sv - shared types and constants for the boot-time instruction loader
package imem_loader_pkg;

   // Loader FSM encoding, shared by RTL and bench
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      LOAD = 2'd1,
      DONE = 2'd2,
      ERR  = 2'd3
   } loader_state_t;

   // Plain-vector aliases so state registers can stay simple logic vectors
   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_LOAD = 2'd1;
   localparam logic [1:0] ST_DONE = 2'd2;
   localparam logic [1:0] ST_ERR  = 2'd3;

   localparam int BYTES_PER_WORD = 4;
   localparam int INSTR_W        = 32;

   // addi x0, x0, 0
   localparam logic [31:0] NOP_INSTR = 32'h00000013;

   // Position a byte in its little-endian lane of an instruction word
   function automatic logic [INSTR_W-1:0] place_byte(input logic [7:0] b, input logic [1:0] lane);
      return {24'd0, b} << {lane, 3'b000};
   endfunction

endpackage

// File: rtl/imem_word_packer.sv
// rtl/imem_word_packer.sv - packs accepted bytes little-endian into 32-bit words
module imem_word_packer
   import imem_loader_pkg::*;
(
   input  logic               clk,
   input  logic               rst_n,
   input  logic               i_flush,
   input  logic               i_byte_valid,
   input  logic [7:0]         i_byte,
   input  logic               i_pad,
   output logic [1:0]         o_byte_cnt,
   output logic               o_word_valid,
   output logic [INSTR_W-1:0] o_word
);

   localparam logic [1:0] LAST_LANE = 2'(BYTES_PER_WORD - 1);

   logic [1:0]         r_byte_cnt;
   logic [INSTR_W-1:0] r_lanes;
   logic               w_complete;
   logic [INSTR_W-1:0] w_word;

   // Lanes above the current count are always zero, so a padded word is
   // simply the stored lanes plus the incoming byte.
   assign w_word       = r_lanes | place_byte(i_byte, r_byte_cnt);
   assign w_complete   = i_byte_valid && ((r_byte_cnt == LAST_LANE) || i_pad);
   assign o_word_valid = w_complete && !i_flush;
   assign o_word       = w_word;
   assign o_byte_cnt   = r_byte_cnt;

   // Lane storage and byte counter; cleared on flush or when a word is emitted
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_byte_cnt <= 2'd0;
         r_lanes    <= '0;
      end else if (i_flush || w_complete) begin
         r_byte_cnt <= 2'd0;
         r_lanes    <= '0;
      end else if (i_byte_valid) begin
         r_byte_cnt <= r_byte_cnt + 2'd1;
         r_lanes    <= w_word;
      end
   end

endmodule

// File: rtl/imem_loader.sv
// rtl/imem_loader.sv - boot loader from byte stream to instruction memory; optional IMEM_LOADER_PAD_EN zero-pads a short final word
module imem_loader
   import imem_loader_pkg::*;
#(
   parameter int ADDR_W = 8
)(
   input  logic               clk,
   input  logic               rst_n,
   input  logic               start,
   input  logic               s_valid,
   input  logic [7:0]         s_data,
   input  logic               s_last,
   output logic               s_ready,
   output logic               imem_we,
   output logic [ADDR_W-1:0]  imem_waddr,
   output logic [INSTR_W-1:0] imem_wdata,
   output logic               cpu_rst,
   output logic [ADDR_W:0]    num_instr,
   output logic               busy,
   output logic               done,
   output logic               err_overflow,
   output logic               err_partial
);

   localparam logic [ADDR_W:0] MAX_WORDS = {1'b1, {ADDR_W{1'b0}}};

   logic [1:0]         r_state;
   logic [ADDR_W-1:0]  r_ptr;
   logic [ADDR_W:0]    r_num;
   logic               r_we;
   logic [ADDR_W-1:0]  r_waddr;
   logic [INSTR_W-1:0] r_wdata;
   logic               r_cpu_rst;
   logic               r_err_ovf;
   logic               r_err_part;

   logic               w_ready;
   logic               w_hs;
   logic               w_full;
   logic               w_overflow;
   logic               w_last_mid;
   logic               w_pad;
   logic               w_part_err;
   logic               w_pack_valid;
   logic               w_flush;
   logic [1:0]         w_byte_cnt;
   logic               w_word_valid;
   logic [INSTR_W-1:0] w_word;

   // start takes the cycle for itself: no byte is accepted while restarting
   assign w_ready    = (r_state == ST_LOAD) && !start;
   assign w_hs       = s_valid && w_ready;
   assign w_full     = (r_num == MAX_WORDS);
   assign w_overflow = w_hs && w_full && (w_byte_cnt == 2'd0);
   assign w_last_mid = w_hs && !w_overflow && s_last && (w_byte_cnt != 2'd3);

`ifdef IMEM_LOADER_PAD_EN
   assign w_pad      = w_last_mid;
   assign w_part_err = 1'b0;
`else
   assign w_pad      = 1'b0;
   assign w_part_err = w_last_mid;
`endif

   // Overflowing bytes are consumed from the stream but never reach the packer
   assign w_pack_valid = w_hs && !w_overflow;
   assign w_flush      = start || w_part_err;

   imem_word_packer u_packer (
      .clk          (clk),
      .rst_n        (rst_n),
      .i_flush      (w_flush),
      .i_byte_valid (w_pack_valid),
      .i_byte       (s_data),
      .i_pad        (w_pad),
      .o_byte_cnt   (w_byte_cnt),
      .o_word_valid (w_word_valid),
      .o_word       (w_word)
   );

   // Loader FSM: start always (re)enters LOAD; LOAD ends in DONE or ERR
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= ST_IDLE;
      end else if (start) begin
         r_state <= ST_LOAD;
      end else if (r_state == ST_LOAD) begin
         if (w_overflow || w_part_err) begin
            r_state <= ST_ERR;
         end else if (w_word_valid && s_last) begin
            r_state <= ST_DONE;
         end
      end
   end

   // Registered write port, write pointer and committed-word counter
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_we    <= 1'b0;
         r_waddr <= '0;
         r_wdata <= '0;
         r_ptr   <= '0;
         r_num   <= '0;
      end else begin
         r_we <= w_word_valid;
         if (start) begin
            r_ptr <= '0;
            r_num <= '0;
         end else if (w_word_valid) begin
            r_waddr <= r_ptr;
            r_wdata <= w_word;
            r_ptr   <= r_ptr + 1'b1;
            if (!w_full) begin
               r_num <= r_num + 1'b1;
            end
         end
      end
   end

   // Sticky error flags, cleared only by start or reset
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_err_ovf  <= 1'b0;
         r_err_part <= 1'b0;
      end else if (start) begin
         r_err_ovf  <= 1'b0;
         r_err_part <= 1'b0;
      end else begin
         if (w_overflow) begin
            r_err_ovf <= 1'b1;
         end
         if (w_part_err) begin
            r_err_part <= 1'b1;
         end
      end
   end

   // CPU reset lags DONE by one cycle so the final write lands first;
   // a start in DONE re-asserts it on the very next cycle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cpu_rst <= 1'b1;
      end else begin
         r_cpu_rst <= !((r_state == ST_DONE) && !start);
      end
   end

   assign s_ready      = w_ready;
   assign imem_we      = r_we;
   assign imem_waddr   = r_waddr;
   assign imem_wdata   = r_wdata;
   assign cpu_rst      = r_cpu_rst;
   assign num_instr    = r_num;
   assign busy         = (r_state == ST_LOAD);
   assign done         = (r_state == ST_DONE);
   assign err_overflow = r_err_ovf;
   assign err_partial  = r_err_part;

endmodule

// File: tb/tb_imem_loader.sv
// tb/tb_imem_loader.sv - self-checking bench for imem_loader (honours IMEM_LOADER_PAD_EN)
module tb_imem_loader;
   import imem_loader_pkg::*;

   localparam int AW   = 2;
   localparam int MAXW = 1 << AW;
`ifdef IMEM_LOADER_PAD_EN
   localparam bit PAD = 1'b1;
`else
   localparam bit PAD = 1'b0;
`endif

   localparam int M_IDLE = 0;
   localparam int M_LOAD = 1;
   localparam int M_DONE = 2;
   localparam int M_ERR  = 3;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          start = 1'b0;
   logic          s_valid = 1'b0;
   logic [7:0]    s_data = 8'h00;
   logic          s_last = 1'b0;
   logic          s_ready;
   logic          imem_we;
   logic [AW-1:0] imem_waddr;
   logic [31:0]   imem_wdata;
   logic          cpu_rst;
   logic [AW:0]   num_instr;
   logic          busy;
   logic          done;
   logic          err_overflow;
   logic          err_partial;

   imem_loader #(.ADDR_W(AW)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .start        (start),
      .s_valid      (s_valid),
      .s_data       (s_data),
      .s_last       (s_last),
      .s_ready      (s_ready),
      .imem_we      (imem_we),
      .imem_waddr   (imem_waddr),
      .imem_wdata   (imem_wdata),
      .cpu_rst      (cpu_rst),
      .num_instr    (num_instr),
      .busy         (busy),
      .done         (done),
      .err_overflow (err_overflow),
      .err_partial  (err_partial)
   );

   always #5 clk = ~clk;

   int n_pass = 0;
   int n_chk  = 0;
   int cyc    = 0;
   int hs_cyc = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
   endtask

   // ---------------- behavioural model ----------------
   int          m_mode = M_IDLE;
   logic [7:0]  m_q[$];
   int          m_num = 0;
   int          m_ptr = 0;
   bit          e_we = 0;
   int          e_waddr = 0;
   logic [31:0] e_wdata = 0;
   bit          e_cpu_rst = 1;
   bit          e_ovf = 0;
   bit          e_part = 0;

   task automatic model_step();
      bit          hs;
      logic [31:0] w;
      if (!rst_n) begin
         m_mode = M_IDLE; m_q.delete(); m_num = 0; m_ptr = 0;
         e_we = 0; e_waddr = 0; e_wdata = 0; e_cpu_rst = 1; e_ovf = 0; e_part = 0;
         return;
      end
      hs = s_valid && (m_mode == M_LOAD) && !start;
      // CPU leaves reset only once a whole cycle has been spent in DONE
      e_cpu_rst = !(m_mode == M_DONE && !start);
      e_we = 0;
      if (start) begin
         m_mode = M_LOAD; m_q.delete(); m_num = 0; m_ptr = 0; e_ovf = 0; e_part = 0;
      end else if (hs) begin
         if (m_num == MAXW && m_q.size() == 0) begin
            e_ovf = 1; m_mode = M_ERR;
         end else begin
            m_q.push_back(s_data);
            if (m_q.size() == 4 || (s_last && PAD)) begin
               w = 0;
               for (int i = 0; i < m_q.size(); i++) w = w + (32'(m_q[i]) << (8 * i));
               e_we = 1; e_waddr = m_ptr % MAXW; e_wdata = w;
               m_ptr++;
               if (m_num < MAXW) m_num++;
               m_q.delete();
               if (s_last) m_mode = M_DONE;
            end else if (s_last) begin
               e_part = 1; m_q.delete(); m_mode = M_ERR;
            end
         end
      end
   endtask

   initial forever begin
      @(posedge clk or negedge rst_n);
      model_step();
   end

   initial forever begin
      @(posedge clk);
      cyc++;
   end

   // ---------------- per-cycle compare and write log ----------------
   int          log_addr[$];
   logic [31:0] log_data[$];

   initial forever begin
      @(negedge clk);
      check("s_ready",      s_ready,      (m_mode == M_LOAD) && !start);
      check("imem_we",      imem_we,      e_we);
      check("imem_waddr",   imem_waddr,   e_waddr);
      check("imem_wdata",   imem_wdata,   e_wdata);
      check("cpu_rst",      cpu_rst,      e_cpu_rst);
      check("num_instr",    num_instr,    m_num);
      check("busy",         busy,         m_mode == M_LOAD);
      check("done",         done,         m_mode == M_DONE);
      check("err_overflow", err_overflow, e_ovf);
      check("err_partial",  err_partial,  e_part);
      if (imem_we) begin
         log_addr.push_back(int'(imem_waddr));
         log_data.push_back(imem_wdata);
      end
   end

   // ---------------- stimulus helpers (all return at posedge+2) ----------------
   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #2;
      end
   endtask

   task automatic pulse_start(input bit with_valid);
      start = 1; s_valid = with_valid; s_data = 8'hEE; s_last = 0;
      tick(1);
      start = 0; s_valid = 0;
   endtask

   task automatic send(input logic [7:0] b, input bit last, input int gap);
      bit acc;
      int tries;
      repeat (gap) begin
         s_valid = 0; s_last = 1'($urandom); s_data = 8'($urandom);
         tick(1);
      end
      s_valid = 1; s_data = b; s_last = last;
      acc = 0; tries = 0;
      while (!acc && tries < 20) begin
         @(negedge clk);
         acc = s_ready;
         hs_cyc = cyc;
         @(posedge clk);
         #2;
         tries++;
      end
      s_valid = 0; s_last = 0;
      if (!acc) begin
         n_chk++;
         $display("FAIL send_timeout: byte %0h not accepted within %0d cycles", b, tries);
      end
   endtask

   task automatic clear_log();
      log_addr.delete();
      log_data.delete();
   endtask

   logic [7:0]  prog[8] = '{8'h13, 8'h00, 8'h50, 8'h00, 8'h93, 8'h00, 8'hA0, 8'h00};
   int          gaps[8] = '{0, 2, 1, 3, 0, 1, 2, 1};
   logic [31:0] nop_word;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      int fall;
      nop_word = NOP_INSTR;

      // reset state
      #17;
      check("rst_cpu_rst", cpu_rst, 1'b1);
      check("rst_we",      imem_we, 1'b0);
      check("rst_num",     num_instr, 0);
      check("rst_busy",    busy, 1'b0);
      check("rst_done",    done, 1'b0);
      check("rst_ready",   s_ready, 1'b0);
      rst_n = 1;
      tick(2);

      // back-to-back two-word program
      clear_log();
      pulse_start(1);
      for (int i = 0; i < 8; i++) send(prog[i], i == 7, 0);
      fall = -1;
      for (int i = 0; i < 10 && fall < 0; i++) begin
         @(negedge clk);
         if (!cpu_rst) fall = cyc - hs_cyc;
      end
      check("t1_cpu_rst_fall", fall, 2);
      tick(2);
      check("t1_nwrites", log_addr.size(), 2);
      if (log_addr.size() == 2) begin
         check("t1_addr0", log_addr[0], 0);
         check("t1_data0", log_data[0], 32'h00500013);
         check("t1_addr1", log_addr[1], 1);
         check("t1_data1", log_data[1], 32'h00A00093);
      end
      check("t1_num",  num_instr, 2);
      check("t1_done", done, 1'b1);

      // same program with gaps and stray s_last while idle on the stream
      clear_log();
      pulse_start(0);
      for (int i = 0; i < 8; i++) send(prog[i], i == 7, gaps[i] + int'($urandom_range(0, 2)));
      tick(3);
      check("t2_nwrites", log_addr.size(), 2);
      if (log_addr.size() == 2) begin
         check("t2_addr0", log_addr[0], 0);
         check("t2_data0", log_data[0], 32'h00500013);
         check("t2_addr1", log_addr[1], 1);
         check("t2_data1", log_data[1], 32'h00A00093);
      end
      check("t2_done", done, 1'b1);
      check("t2_cpu_rst", cpu_rst, 1'b0);

      // s_last on second byte of word 1
      clear_log();
      pulse_start(0);
      send(8'h13, 0, 0); send(8'h00, 0, 0); send(8'h50, 0, 0); send(8'h00, 0, 0);
      send(8'hB3, 0, 0); send(8'h00, 1, 0);
      tick(3);
      if (PAD) begin
         check("t3_nwrites", log_addr.size(), 2);
         if (log_addr.size() == 2) begin
            check("t3_addr1", log_addr[1], 1);
            check("t3_data1", log_data[1], 32'h000000B3);
         end
         check("t3_done", done, 1'b1);
         check("t3_num", num_instr, 2);
         check("t3_err_partial", err_partial, 1'b0);
      end else begin
         check("t3_nwrites", log_addr.size(), 1);
         check("t3_err_partial", err_partial, 1'b1);
         check("t3_cpu_rst", cpu_rst, 1'b1);
         check("t3_done", done, 1'b0);
         check("t3_num", num_instr, 1);
      end

      // overflow: 16 bytes fill the 4-word memory, 17th byte is dropped
      clear_log();
      pulse_start(0);
      for (int i = 0; i < 16; i++) send(8'(i), 0, 0);
      send(8'hFF, 0, 0);
      tick(2);
      check("t4_nwrites", log_addr.size(), 4);
      if (log_addr.size() == 4) begin
         check("t4_data0", log_data[0], 32'h03020100);
         check("t4_addr3", log_addr[3], 3);
         check("t4_data3", log_data[3], 32'h0F0E0D0C);
      end
      check("t4_num", num_instr, 4);
      check("t4_err_overflow", err_overflow, 1'b1);
      check("t4_busy", busy, 1'b0);
      check("t4_done", done, 1'b0);
      check("t4_cpu_rst", cpu_rst, 1'b1);

      // restart after 5 bytes, then a one-word program
      clear_log();
      pulse_start(0);
      send(8'h11, 0, 0); send(8'h22, 0, 0); send(8'h33, 0, 0); send(8'h44, 0, 0); send(8'h55, 0, 0);
      pulse_start(1);
      for (int i = 0; i < 4; i++) send(prog[i], i == 3, 0);
      tick(2);
      check("t5_nwrites", log_addr.size(), 2);
      if (log_addr.size() == 2) begin
         check("t5_addr0", log_addr[0], 0);
         check("t5_data0", log_data[0], 32'h44332211);
         check("t5_addr1", log_addr[1], 0);
         check("t5_data1", log_data[1], 32'h00500013);
      end
      check("t5_num", num_instr, 1);
      check("t5_done", done, 1'b1);
      check("t5_err_overflow", err_overflow, 1'b0);

      // asynchronous reset mid-word, checked before any clock edge
      clear_log();
      pulse_start(0);
      for (int i = 0; i < 4; i++) send(prog[i], 0, 0);
      check("t6_we_before", imem_we, 1'b1);
      send(8'h93, 0, 0);
      s_valid = 1; s_data = 8'h00;
      rst_n = 0;
      #1;
      check("t6_we",     imem_we, 1'b0);
      check("t6_waddr",  imem_waddr, 0);
      check("t6_wdata",  imem_wdata, 0);
      check("t6_cpu",    cpu_rst, 1'b1);
      check("t6_num",    num_instr, 0);
      check("t6_busy",   busy, 1'b0);
      check("t6_ready",  s_ready, 1'b0);
      s_valid = 0;
      @(posedge clk);
      #2;
      rst_n = 1;
      tick(1);

      // recovery after reset: a single NOP program
      clear_log();
      pulse_start(0);
      for (int i = 0; i < 4; i++) send(8'(nop_word >> (8 * i)), i == 3, 0);
      tick(2);
      check("t7_nwrites", log_addr.size(), 1);
      if (log_addr.size() == 1) check("t7_data0", log_data[0], NOP_INSTR);
      check("t7_done", done, 1'b1);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
